// File: rtl/integer_datapath.sv
// 32-bit MIPS-style integer datapath: 32x32 register file, combinational ALU with HI/LO and result mux.
// Optional macro INTEGER_DATAPATH_DIV_EN enables the signed divider on FS=0x15.
module integer_datapath (
   input  logic        clk,
   input  logic        reset,
   input  logic        D_En,
   input  logic [4:0]  D_Addr,
   input  logic [4:0]  S_Addr,
   input  logic [4:0]  T_Addr,
   input  logic [4:0]  FS,
   input  logic        HILO_ld,
   input  logic [31:0] DT,
   input  logic        T_Sel,
   input  logic [31:0] DY,
   input  logic [31:0] PC_in,
   input  logic [2:0]  Y_Sel,
   output logic        C,
   output logic        V,
   output logic        N,
   output logic        Z,
   output logic [31:0] ALU_OUT,
   output logic [31:0] D_OUT
);

   localparam logic [4:0] FS_PASS_S = 5'h00, FS_PASS_T = 5'h01, FS_ADD  = 5'h02, FS_ADDU = 5'h03,
                          FS_SUB    = 5'h04, FS_SUBU   = 5'h05, FS_SLT  = 5'h06, FS_SLTU = 5'h07,
                          FS_AND    = 5'h08, FS_OR     = 5'h09, FS_XOR  = 5'h0A, FS_NOR  = 5'h0B,
                          FS_SLL    = 5'h0C, FS_SRL    = 5'h0D, FS_SRA  = 5'h0E, FS_INC  = 5'h0F,
                          FS_DEC    = 5'h10, FS_ZEROS  = 5'h11, FS_ONES = 5'h12, FS_LUI  = 5'h13,
                          FS_MUL    = 5'h14, FS_DIV    = 5'h15;

   logic [31:0][31:0] rf;
   logic [31:0]       hi, lo;
   logic [31:0]       a, b, t_rd;
   logic [31:0]       y_lo, y_hi;
   logic [32:0]       sum, diff;
   logic [63:0]       prod;
   logic              c_f, v_f, flag_en, wide_z;

   // R0 is hardwired to zero on the read side; writes to it are also suppressed below.
   assign a     = (S_Addr == 5'd0) ? 32'd0 : rf[S_Addr];
   assign t_rd  = (T_Addr == 5'd0) ? 32'd0 : rf[T_Addr];
   assign b     = T_Sel ? t_rd : DT;
   assign D_OUT = t_rd;

   assign sum  = {1'b0, a} + {1'b0, b};
   assign diff = {1'b0, a} - {1'b0, b};
   assign prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf <= '0;
      end else if (D_En && D_Addr != 5'd0) begin
         rf[D_Addr] <= ALU_OUT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (HILO_ld) begin
         hi <= y_hi;
         lo <= y_lo;
      end
   end

   always_comb begin
      y_lo    = '0;
      y_hi    = '0;
      c_f     = 1'b0;
      v_f     = 1'b0;
      flag_en = 1'b1;
      wide_z  = 1'b0;
      case (FS)
         FS_PASS_S: y_lo = a;
         FS_PASS_T: y_lo = b;
         FS_ADD: begin
            y_lo = sum[31:0];
            c_f  = sum[32];
            v_f  = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         FS_ADDU: begin
            y_lo = sum[31:0];
            c_f  = sum[32];
         end
         FS_SUB: begin
            y_lo = diff[31:0];
            c_f  = diff[32];
            v_f  = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         FS_SUBU: begin
            y_lo = diff[31:0];
            c_f  = diff[32];
         end
         FS_SLT:   y_lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         FS_SLTU:  y_lo = (a < b) ? 32'd1 : 32'd0;
         FS_AND:   y_lo = a & b;
         FS_OR:    y_lo = a | b;
         FS_XOR:   y_lo = a ^ b;
         FS_NOR:   y_lo = ~(a | b);
         FS_SLL:   y_lo = b << a[4:0];
         FS_SRL:   y_lo = b >> a[4:0];
         FS_SRA:   y_lo = $signed(b) >>> a[4:0];
         FS_INC: begin
            y_lo = a + 32'd1;
            c_f  = (a == 32'hFFFF_FFFF);
            v_f  = (a == 32'h7FFF_FFFF);
         end
         FS_DEC: begin
            y_lo = a - 32'd1;
            c_f  = (a == 32'd0);
            v_f  = (a == 32'h8000_0000);
         end
         FS_ZEROS: y_lo = 32'd0;
         FS_ONES:  y_lo = 32'hFFFF_FFFF;
         FS_LUI:   y_lo = {b[15:0], 16'h0};
         FS_MUL: begin
            {y_hi, y_lo} = prod;
            wide_z       = 1'b1;
         end
`ifdef INTEGER_DATAPATH_DIV_EN
         FS_DIV: begin
            wide_z = 1'b1;
            // Divide by zero saturates the quotient and hands back the dividend as remainder.
            if (b == 32'd0) begin
               y_lo = 32'hFFFF_FFFF;
               y_hi = a;
            end else begin
               y_lo = $signed(a) / $signed(b);
               y_hi = $signed(a) % $signed(b);
            end
         end
`endif
         default: flag_en = 1'b0;
      endcase
   end

   assign C = flag_en & c_f;
   assign V = flag_en & v_f;
   assign N = flag_en & ((FS == FS_MUL) ? y_hi[31] : y_lo[31]);
   assign Z = flag_en & (wide_z ? ({y_hi, y_lo} == 64'd0) : (y_lo == 32'd0));

   always_comb begin
      case (Y_Sel)
         3'b000:  ALU_OUT = hi;
         3'b001:  ALU_OUT = lo;
         3'b010:  ALU_OUT = y_lo;
         3'b011:  ALU_OUT = DY;
         3'b100:  ALU_OUT = PC_in;
         default: ALU_OUT = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_integer_datapath.sv
// Directed self-checking bench for integer_datapath; hand-computed expectations.
// DIV vectors follow INTEGER_DATAPATH_DIV_EN; without it FS=0x15 must behave as an unused code.
module tb_integer_datapath;

   logic        clk = 1'b0;
   logic        reset;
   logic        D_En, HILO_ld, T_Sel, C, V, N, Z;
   logic [4:0]  D_Addr, S_Addr, T_Addr, FS;
   logic [31:0] DT, DY, PC_in, ALU_OUT, D_OUT;
   logic [2:0]  Y_Sel;
   int          checks = 0;
   int          errors = 0;

   integer_datapath dut (
      .clk(clk), .reset(reset), .D_En(D_En), .D_Addr(D_Addr), .S_Addr(S_Addr), .T_Addr(T_Addr),
      .FS(FS), .HILO_ld(HILO_ld), .DT(DT), .T_Sel(T_Sel), .DY(DY), .PC_in(PC_in), .Y_Sel(Y_Sel),
      .C(C), .V(V), .N(N), .Z(Z), .ALU_OUT(ALU_OUT), .D_OUT(D_OUT)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Flags packed as {C,V,N,Z}.
   task automatic chk_flags(input string tag, input logic [3:0] exp);
      chk(tag, {28'd0, C, V, N, Z}, {28'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write a constant into a register through PASS_T with B taken from DT.
   task automatic wr(input logic [4:0] r, input logic [31:0] val);
      D_En = 1'b1; D_Addr = r; T_Sel = 1'b0; FS = 5'h01; Y_Sel = 3'b010; DT = val;
      tick();
      D_En = 1'b0;
   endtask

   initial begin
      reset = 1'b1; D_En = 0; HILO_ld = 0; T_Sel = 0; D_Addr = 0; S_Addr = 0; T_Addr = 0;
      FS = 0; DT = 0; DY = 0; PC_in = 0; Y_Sel = 3'b000;
      #20;
      chk("rst_alu_out", ALU_OUT, 32'd0);
      chk_flags("rst_flags", 4'b0001);
      #30;
      reset = 1'b0;
      @(negedge clk);

      FS = 5'h00; Y_Sel = 3'b010;
      for (int i = 0; i < 32; i++) begin
         S_Addr = 5'(i); T_Addr = 5'(i);
         #1;
         chk($sformatf("dump_alu_r%0d", i), ALU_OUT, 32'd0);
         chk($sformatf("dump_dout_r%0d", i), D_OUT, 32'd0);
      end

      // Same-cycle read of the register being written still shows the old value.
      T_Addr = 5'd1; D_En = 1'b1; D_Addr = 5'd1; T_Sel = 1'b0; FS = 5'h01; DT = 32'h1111_1111;
      #1;
      chk("no_bypass", D_OUT, 32'd0);
      for (int i = 1; i < 16; i++) wr(5'(i), 32'(i) * 32'h1111_1111);
      wr(5'd0, 32'hDEAD_BEEF);
      FS = 5'h00; Y_Sel = 3'b010;
      for (int i = 0; i < 16; i++) begin
         S_Addr = 5'(i); T_Addr = 5'(i);
         #1;
         chk($sformatf("rd_alu_r%0d", i), ALU_OUT, 32'(i) * 32'h1111_1111);
         chk($sformatf("rd_dout_r%0d", i), D_OUT, 32'(i) * 32'h1111_1111);
      end

      wr(5'd16, 32'h7FFF_FFFF);
      wr(5'd17, 32'hFFFF_FFFF);
      wr(5'd18, 32'hFFFF_FFFD);
      wr(5'd19, 32'd7);
      T_Sel = 1'b0; Y_Sel = 3'b010;

      FS = 5'h02; S_Addr = 5'd16; DT = 32'd1; #1;
      chk("add_ovf", ALU_OUT, 32'h8000_0000);
      chk_flags("add_ovf_flags", 4'b0110);
      FS = 5'h03; S_Addr = 5'd17; DT = 32'd1; #1;
      chk("addu_wrap", ALU_OUT, 32'd0);
      chk_flags("addu_wrap_flags", 4'b1001);
      FS = 5'h04; S_Addr = 5'd1; DT = 32'h2222_2222; #1;
      chk("sub_borrow", ALU_OUT, 32'hEEEE_EEEF);
      chk_flags("sub_borrow_flags", 4'b1010);
      FS = 5'h05; S_Addr = 5'd2; T_Addr = 5'd1; T_Sel = 1'b1; #1;
      chk("subu_tport", ALU_OUT, 32'h1111_1111);
      chk_flags("subu_tport_flags", 4'b0000);
      T_Sel = 1'b0;
      FS = 5'h06; S_Addr = 5'd17; DT = 32'd1; #1;
      chk("slt", ALU_OUT, 32'd1);
      FS = 5'h07; #1;
      chk("sltu", ALU_OUT, 32'd0);
      FS = 5'h0E; S_Addr = 5'd4; DT = 32'h8000_0000; #1;
      chk("sra", ALU_OUT, 32'hF800_0000);
      FS = 5'h0D; #1;
      chk("srl", ALU_OUT, 32'h0800_0000);
      FS = 5'h0C; DT = 32'h0000_0011; #1;
      chk("sll", ALU_OUT, 32'h0000_0110);
      FS = 5'h13; DT = 32'h1234_ABCD; #1;
      chk("lui", ALU_OUT, 32'hABCD_0000);
      FS = 5'h0B; S_Addr = 5'd0; DT = 32'd0; #1;
      chk("nor", ALU_OUT, 32'hFFFF_FFFF);
      chk_flags("nor_flags", 4'b0010);
      FS = 5'h0F; S_Addr = 5'd16; #1;
      chk("inc_ovf", ALU_OUT, 32'h8000_0000);
      chk_flags("inc_ovf_flags", 4'b0110);
      FS = 5'h10; S_Addr = 5'd0; #1;
      chk("dec_borrow", ALU_OUT, 32'hFFFF_FFFF);
      chk_flags("dec_borrow_flags", 4'b1010);
      FS = 5'h1F; S_Addr = 5'd1; #1;
      chk("unused_fs", ALU_OUT, 32'd0);
      chk_flags("unused_fs_flags", 4'b0000);

      FS = 5'h14; S_Addr = 5'd18; DT = 32'd5; HILO_ld = 1'b1; #1;
      chk("mul_lo_comb", ALU_OUT, 32'hFFFF_FFF1);
      chk_flags("mul_flags", 4'b0010);
      tick();
      HILO_ld = 1'b0; FS = 5'h00;
      Y_Sel = 3'b001; #1;
      chk("mul_lo", ALU_OUT, 32'hFFFF_FFF1);
      Y_Sel = 3'b000; #1;
      chk("mul_hi", ALU_OUT, 32'hFFFF_FFFF);

`ifdef INTEGER_DATAPATH_DIV_EN
      FS = 5'h15; S_Addr = 5'd19; DT = 32'hFFFF_FFFE; HILO_ld = 1'b1;
      tick();
      Y_Sel = 3'b001; #1;
      chk("div_lo", ALU_OUT, 32'hFFFF_FFFD);
      Y_Sel = 3'b000; #1;
      chk("div_hi", ALU_OUT, 32'd1);
      DT = 32'd0;
      tick();
      Y_Sel = 3'b001; #1;
      chk("div0_lo", ALU_OUT, 32'hFFFF_FFFF);
      Y_Sel = 3'b000; #1;
      chk("div0_hi", ALU_OUT, 32'd7);
      HILO_ld = 1'b0;
`else
      FS = 5'h15; S_Addr = 5'd19; DT = 32'hFFFF_FFFE; Y_Sel = 3'b010; #1;
      chk("div_off", ALU_OUT, 32'd0);
      chk_flags("div_off_flags", 4'b0000);
      HILO_ld = 1'b1;
      tick();
      HILO_ld = 1'b0; Y_Sel = 3'b000; #1;
      chk("div_off_hi", ALU_OUT, 32'd0);
`endif

      // Mid-sequence reset: a write lands, then reset clears everything before the next edge.
      wr(5'd5, 32'hCAFE_F00D);
      FS = 5'h00; Y_Sel = 3'b010; S_Addr = 5'd5; T_Addr = 5'd5; #1;
      chk("pre_rst_r5", ALU_OUT, 32'hCAFE_F00D);
      #1 reset = 1'b1;
      #1;
      chk("async_rst_r5", ALU_OUT, 32'd0);
      S_Addr = 5'd1; T_Addr = 5'd15; #1;
      chk("async_rst_r1", ALU_OUT, 32'd0);
      chk("async_rst_r15", D_OUT, 32'd0);
      Y_Sel = 3'b001; #1;
      chk("async_rst_lo", ALU_OUT, 32'd0);
      D_En = 1'b1; D_Addr = 5'd6; FS = 5'h01; Y_Sel = 3'b010; DT = 32'h1234_5678;
      tick();
      D_En = 1'b0; reset = 1'b0; FS = 5'h00; S_Addr = 5'd6; #1;
      chk("rst_blocks_write", ALU_OUT, 32'd0);

      Y_Sel = 3'b100; PC_in = 32'h0040_0004; #1;
      chk("ysel_pc", ALU_OUT, 32'h0040_0004);
      Y_Sel = 3'b011; DY = 32'h5A5A_A5A5; #1;
      chk("ysel_dy", ALU_OUT, 32'h5A5A_A5A5);
      Y_Sel = 3'b110; #1;
      chk("ysel_unused", ALU_OUT, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
